alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a registered result and zero/carry flags. Most opcodes finish one cycle after start.
// Defining ALU_SEQ_MUL_EN adds a shift-add multiplier (opcode 1011) that finishes WIDTH+1 cycles after start.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [3:0]       ALU_OP,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             SKZ_cmp,
    output logic             carry
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_STO = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1011;
    localparam int         CW     = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;
`else
    typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

    state_t state, state_next;

    // Returns {zero, carry, result} for every single-cycle opcode.
    function automatic logic [WIDTH+1:0] alu_eval(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             z;
        wide = '0;
        r    = a;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            OP_LDA: r = b;
            OP_STO: r = a;
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_SHL: begin
                r = a << 1;
                c = a[WIDTH-1];
            end
            OP_SHR: begin
                r = a >> 1;
                c = a[0];
            end
            default: r = a;
        endcase
        // Pass-through and store opcodes report the accumulator, not the result.
        case (op)
            4'b0000, 4'b0001, 4'b0110, 4'b0111: z = (a == '0);
            default:                            z = (r == '0);
        endcase
        return {z, c, r};
    endfunction

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_last;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_last = (count == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ALU_SEQ_MUL_EN
                    state_next = (ALU_OP == OP_MUL) ? MUL_RUN : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL_RUN: begin
                if (mul_last) begin
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            SKZ_cmp <= 1'b0;
            carry   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
`endif
        end else begin
            if (state == IDLE && start) begin
`ifdef ALU_SEQ_MUL_EN
                if (ALU_OP == OP_MUL) begin
                    mcand  <= {{WIDTH{1'b0}}, inA};
                    mplier <= inB;
                    acc    <= '0;
                    count  <= '0;
                end else begin
                    {SKZ_cmp, carry, result} <= alu_eval(ALU_OP, inA, inB);
                end
`else
                {SKZ_cmp, carry, result} <= alu_eval(ALU_OP, inA, inB);
`endif
            end
`ifdef ALU_SEQ_MUL_EN
            // One multiplier bit per cycle; the final partial sum goes straight to the outputs.
            if (state == MUL_RUN) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (mul_last) begin
                    result  <= acc_next[WIDTH-1:0];
                    carry   <= |acc_next[2*WIDTH-1:WIDTH];
                    SKZ_cmp <= (acc_next[WIDTH-1:0] == '0);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq: a cycle-level behavioural model is checked every cycle,
// and directed operations with literal expectations pin the model.
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LDA = 4'b0101;
    localparam logic [3:0] OP_STO = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic [3:0]   ALU_OP = '0;
    logic         start = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         SKZ_cmp;
    logic         carry;

    int checks = 0;
    int passed = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .inA    (inA),
        .inB    (inB),
        .ALU_OP (ALU_OP),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .result (result),
        .SKZ_cmp(SKZ_cmp),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Arithmetic reference: result, carry, zero flag and cycles from start to done.
    function automatic void ref_op(input int op, input int a, input int b,
                                   output int r, output int c, output int z, output int l);
        int     m;
        longint p;
        m = 1 << W;
        l = 1;
        c = 0;
        r = a;
        case (op)
            2:  begin r = (a + b) % m; c = ((a + b) >= m) ? 1 : 0; end
            3:  r = a & b;
            4:  r = a ^ b;
            5:  r = b;
            6:  r = a;
            8:  begin r = (a - b + m) % m; c = (a < b) ? 1 : 0; end
            9:  begin r = (a * 2) % m; c = (a >= m / 2) ? 1 : 0; end
            10: begin r = a / 2; c = a % 2; end
`ifdef ALU_SEQ_MUL_EN
            11: begin
                p = longint'(a) * longint'(b);
                r = int'(p % m);
                c = ((p / m) != 0) ? 1 : 0;
                l = W + 1;
            end
`endif
            default: r = a;
        endcase
        if (op inside {0, 1, 6, 7}) z = (a == 0) ? 1 : 0;
        else                        z = (r == 0) ? 1 : 0;
    endfunction

    // cyc counts cycles since an accepted start (0 = idle); outputs land in cycle lat.
    int cyc = 0, lat = 1;
    int p_r = 0, p_c = 0, p_z = 0;
    int e_r = 0, e_c = 0, e_z = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0;
            e_r = 0; e_c = 0; e_z = 0;
        end else begin
            if (cyc > 0) begin
                cyc = (cyc == lat) ? 0 : cyc + 1;
            end else if (start) begin
                ref_op(int'(ALU_OP), int'(inA), int'(inB), p_r, p_c, p_z, lat);
                cyc = 1;
            end
            if (cyc > 0 && cyc == lat) begin
                e_r = p_r; e_c = p_c; e_z = p_z;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",    busy,    (cyc > 0) ? 1 : 0);
        chk("done",    done,    (cyc > 0 && cyc == lat) ? 1 : 0);
        chk("result",  result,  e_r);
        chk("carry",   carry,   e_c);
        chk("SKZ_cmp", SKZ_cmp, e_z);
    end

    task automatic wait_idle();
        for (int k = 0; k < 50 && busy; k++) @(negedge clk);
        chk("idle before start", busy, 0);
    endtask

    task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [W-1:0] er,
                          input logic ec, input logic ez, input int ign_at);
        int n;
        bit got;
        wait_idle();
        inA = a; inB = b; ALU_OP = op; start = 1'b1;
        got = 0;
        n = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            n = k;
            if (done) got = 1;
            else begin
                start = (k == ign_at);
                if (k == ign_at) begin
                    ALU_OP = OP_ADD; inA = 8'h01; inB = 8'h02;
                end
            end
        end
        start = 1'b0;
        chk({nm, " done seen"}, got, 1);
        chk({nm, " latency"}, n, exp_lat);
        chk({nm, " result"}, result, er);
        chk({nm, " carry"}, carry, ec);
        chk({nm, " zero"}, SKZ_cmp, ez);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset result", result, 0);
        chk("reset carry", carry, 0);
        chk("reset zero", SKZ_cmp, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst = 1'b0;

        run_op("ADD FF+01", OP_ADD, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1, 0);
        run_op("SUB 03-05", OP_SUB, 8'h03, 8'h05, 1, 8'hFE, 1'b1, 1'b0, 0);
        run_op("STO 00",    OP_STO, 8'h00, 8'h7A, 1, 8'h00, 1'b0, 1'b1, 0);
        run_op("LDA 7A",    OP_LDA, 8'h00, 8'h7A, 1, 8'h7A, 1'b0, 1'b0, 0);
        run_op("SHL 81",    OP_SHL, 8'h81, 8'h00, 1, 8'h02, 1'b1, 1'b0, 0);
        run_op("SHR 81",    OP_SHR, 8'h81, 8'h00, 1, 8'h40, 1'b1, 1'b0, 0);
        run_op("AND F0 0F", OP_AND, 8'hF0, 8'h0F, 1, 8'h00, 1'b0, 1'b1, 0);
        run_op("op0 A=0",   4'h0,   8'h00, 8'h05, 1, 8'h00, 1'b0, 1'b1, 0);
        run_op("opF A=5A",  4'hF,   8'h5A, 8'h00, 1, 8'h5A, 1'b0, 1'b0, 0);
`ifdef ALU_SEQ_MUL_EN
        run_op("MUL 10*11", OP_MUL, 8'h10, 8'h11, 9, 8'h10, 1'b1, 1'b0, 3);
        run_op("MUL FF*FF", OP_MUL, 8'hFF, 8'hFF, 9, 8'h01, 1'b1, 1'b0, 0);
`else
        run_op("1011 pass", OP_MUL, 8'h21, 8'h11, 1, 8'h21, 1'b0, 1'b0, 3);
`endif

        // Asynchronous reset four cycles into an operation.
        wait_idle();
        inA = 8'h10; inB = 8'h11; ALU_OP = OP_MUL; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid rst result", result, 0);
        chk("mid rst carry", carry, 0);
        chk("mid rst zero", SKZ_cmp, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst done", done, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        run_op("XOR AA^FF", OP_XOR, 8'hAA, 8'hFF, 1, 8'h55, 1'b0, 1'b0, 0);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                chk("rand rst result", result, 0);
                chk("rand rst busy", busy, 0);
                @(negedge clk);
                #1 rst = 1'b0;
            end else begin
                inA    = W'($urandom);
                inB    = W'($urandom);
                ALU_OP = ($urandom_range(0, 3) == 0) ? OP_MUL : 4'($urandom_range(0, 15));
                start  = ($urandom_range(0, 2) == 0);
            end
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
